// File: rtl/lsu_atomic_pkg.sv
// Shared types for the atomic load-store unit: core scheduler stages, LSU states
// and the decoded memory operation, plus the operation priority helper.
package lsu_atomic_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } corestate_t;

    typedef enum logic [2:0] {
        LSU_IDLE    = 3'd0,
        LSU_REQ_RD  = 3'd1,
        LSU_WAIT_RD = 3'd2,
        LSU_REQ_WR  = 3'd3,
        LSU_WAIT_WR = 3'd4,
        LSU_DONE    = 3'd5
    } lsu_atomic_state_t;

    typedef enum logic [1:0] {
        OP_NONE   = 2'd0,
        OP_LOAD   = 2'd1,
        OP_STORE  = 2'd2,
        OP_ATOMIC = 2'd3
    } lsu_op_t;

    // Atomic beats load beats store when several decode bits are set at once.
    function automatic lsu_op_t select_op(input logic atomic, input logic read, input logic write);
        if (atomic) return OP_ATOMIC;
        if (read)   return OP_LOAD;
        if (write)  return OP_STORE;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/lsu_atomic_if.sv
// Data-memory controller bus seen by one LSU: a read channel and a write channel,
// each a valid/ready handshake.
interface lsu_atomic_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8
);
    logic                 read_valid;
    logic [ADDR_BITS-1:0] read_address;
    logic                 read_ready;
    logic [DATA_BITS-1:0] read_data;
    logic                 write_valid;
    logic [ADDR_BITS-1:0] write_address;
    logic [DATA_BITS-1:0] write_data;
    logic                 write_ready;

    modport master (
        output read_valid, read_address,
        input  read_ready, read_data,
        output write_valid, write_address, write_data,
        input  write_ready
    );

    modport slave (
        input  read_valid, read_address,
        output read_ready, read_data,
        input  write_valid, write_address, write_data,
        output write_ready
    );
endinterface

// File: rtl/lsu_atomic_timeout_counter.sv
// Wait-cycle budget for one memory phase; expired pulses on the counting cycle
// that brings the count up to TIMEOUT_CYCLES (never when TIMEOUT_CYCLES is 0).
module lsu_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int            CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic          ACTIVE = (TIMEOUT_CYCLES > 0);

    logic [CW-1:0] count_reg;

    assign expired = ACTIVE && count_en && (count_reg == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_en && ACTIVE) begin
            count_reg <= count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/lsu_atomic.sv
// Per-thread load/store unit with atomic fetch-and-add: operands are captured at
// request time, every memory wait is bounded and a timeout is reported in lsu_error.
module lsu_atomic
    import lsu_atomic_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int ADDR_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  corestate_t            core_state,
    input  logic                  decoded_mem_read_enable,
    input  logic                  decoded_mem_write_enable,
    input  logic                  decoded_mem_atomic_enable,
    input  logic [ADDR_BITS-1:0]  rs,
    input  logic [DATA_BITS-1:0]  rt,
    lsu_atomic_if.master          mem,
    output lsu_atomic_state_t     lsu_state,
    output logic [DATA_BITS-1:0]  lsu_out,
    output logic                  lsu_error
);
    lsu_atomic_state_t    state_reg;
    lsu_op_t              op_reg;
    logic [ADDR_BITS-1:0] addr_reg;
    logic [DATA_BITS-1:0] operand_reg;
    logic [DATA_BITS-1:0] wdata_reg;
    logic [DATA_BITS-1:0] out_reg;
    logic                 error_reg;
    logic                 read_valid_reg;
    logic                 write_valid_reg;
    logic [ADDR_BITS-1:0] read_address_reg;
    logic [ADDR_BITS-1:0] write_address_reg;
    logic [DATA_BITS-1:0] write_data_reg;

    lsu_op_t op_sel;
    logic    ready_hit;
    logic    tmo_clear;
    logic    tmo_count;
    logic    tmo_expired;

    // Only the ready belonging to the channel being waited on counts.
    always_comb begin
        op_sel    = select_op(decoded_mem_atomic_enable, decoded_mem_read_enable,
                              decoded_mem_write_enable);
        ready_hit = ((state_reg == LSU_WAIT_RD) && mem.read_ready) ||
                    ((state_reg == LSU_WAIT_WR) && mem.write_ready);
        tmo_clear = enable && ((state_reg == LSU_REQ_RD) || (state_reg == LSU_REQ_WR));
        tmo_count = enable && ((state_reg == LSU_WAIT_RD) || (state_reg == LSU_WAIT_WR))
                    && !ready_hit;
    end

    lsu_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmo_clear),
        .count_en (tmo_count),
        .expired  (tmo_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= LSU_IDLE;
            op_reg            <= OP_NONE;
            addr_reg          <= '0;
            operand_reg       <= '0;
            wdata_reg         <= '0;
            out_reg           <= '0;
            error_reg         <= 1'b0;
            read_valid_reg    <= 1'b0;
            write_valid_reg   <= 1'b0;
            read_address_reg  <= '0;
            write_address_reg <= '0;
            write_data_reg    <= '0;
        end else if (enable) begin
            case (state_reg)
                LSU_IDLE: begin
                    if (core_state == CORE_REQUEST && op_sel != OP_NONE) begin
                        op_reg      <= op_sel;
                        addr_reg    <= rs;
                        operand_reg <= rt;
                        wdata_reg   <= rt;
                        error_reg   <= 1'b0;
                        state_reg   <= (op_sel == OP_STORE) ? LSU_REQ_WR : LSU_REQ_RD;
                    end
                end
                LSU_REQ_RD: begin
                    read_valid_reg   <= 1'b1;
                    read_address_reg <= addr_reg;
                    state_reg        <= LSU_WAIT_RD;
                end
                LSU_WAIT_RD: begin
                    // Ready is tested first so a ready on the final budget cycle succeeds.
                    if (mem.read_ready) begin
                        read_valid_reg <= 1'b0;
                        out_reg        <= mem.read_data;
                        if (op_reg == OP_ATOMIC) begin
                            wdata_reg <= mem.read_data + operand_reg;
                            state_reg <= LSU_REQ_WR;
                        end else begin
                            state_reg <= LSU_DONE;
                        end
                    end else if (tmo_expired) begin
                        read_valid_reg <= 1'b0;
                        error_reg      <= 1'b1;
                        state_reg      <= LSU_DONE;
                    end
                end
                LSU_REQ_WR: begin
                    write_valid_reg   <= 1'b1;
                    write_address_reg <= addr_reg;
                    write_data_reg    <= wdata_reg;
                    state_reg         <= LSU_WAIT_WR;
                end
                LSU_WAIT_WR: begin
                    if (mem.write_ready) begin
                        write_valid_reg <= 1'b0;
                        state_reg       <= LSU_DONE;
                    end else if (tmo_expired) begin
                        write_valid_reg <= 1'b0;
                        error_reg       <= 1'b1;
                        state_reg       <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    if (core_state == CORE_UPDATE) begin
                        state_reg <= LSU_IDLE;
                    end
                end
                default: state_reg <= LSU_IDLE;
            endcase
        end
    end

    assign mem.read_valid    = read_valid_reg;
    assign mem.read_address  = read_address_reg;
    assign mem.write_valid   = write_valid_reg;
    assign mem.write_address = write_address_reg;
    assign mem.write_data    = write_data_reg;
    assign lsu_state         = state_reg;
    assign lsu_out           = out_reg;
    assign lsu_error         = error_reg;
endmodule

// File: tb/tb_lsu_atomic.sv
// Bench for lsu_atomic: a delay-programmable memory responder plus an
// operation-level reference model of memory contents, results, errors and latency.
module tb_lsu_atomic;
    import lsu_atomic_pkg::*;

    localparam int TMO   = 4;
    localparam int NEVER = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    corestate_t        core_state;
    logic              decoded_mem_read_enable;
    logic              decoded_mem_write_enable;
    logic              decoded_mem_atomic_enable;
    logic [7:0]        rs;
    logic [7:0]        rt;
    lsu_atomic_state_t lsu_state;
    logic [7:0]        lsu_out;
    logic              lsu_error;

    lsu_atomic_if #(.DATA_BITS(8), .ADDR_BITS(8)) bus ();

    lsu_atomic #(.DATA_BITS(8), .ADDR_BITS(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .enable                    (enable),
        .core_state                (core_state),
        .decoded_mem_read_enable   (decoded_mem_read_enable),
        .decoded_mem_write_enable  (decoded_mem_write_enable),
        .decoded_mem_atomic_enable (decoded_mem_atomic_enable),
        .rs                        (rs),
        .rt                        (rt),
        .mem                       (bus),
        .lsu_state                 (lsu_state),
        .lsu_out                   (lsu_out),
        .lsu_error                 (lsu_error)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] mem_array [256];
    logic [7:0] ref_mem   [256];
    logic [7:0] model_out = 8'h00;
    int         rd_delay = 0, wr_delay = 0;

    // Responder state, written only by the responder process.
    int         rd_cnt = 0, wr_cnt = 0, wr_commits = 0;
    logic [7:0] last_rd_addr = 8'h00, last_wr_addr = 8'h00, last_wr_data = 8'h00;
    logic       overlap_seen = 1'b0;

    // Ready is raised 'delay' cycles after valid is first seen, for one cycle only.
    always @(negedge clk) begin
        if (bus.read_valid && bus.write_valid) overlap_seen = 1'b1;
        if (bus.read_valid) begin
            bus.read_ready = (rd_cnt == rd_delay);
            if (bus.read_ready) begin
                bus.read_data = mem_array[bus.read_address];
                last_rd_addr  = bus.read_address;
            end else begin
                bus.read_data = 8'($urandom);
            end
            rd_cnt++;
        end else begin
            bus.read_ready = 1'b0;
            bus.read_data  = 8'($urandom);
            rd_cnt = 0;
        end
        if (bus.write_valid) begin
            bus.write_ready = (wr_cnt == wr_delay);
            if (bus.write_ready) begin
                last_wr_addr = bus.write_address;
                last_wr_data = bus.write_data;
                wr_commits++;
            end
            wr_cnt++;
        end else begin
            bus.write_ready = 1'b0;
            wr_cnt = 0;
        end
    end

    function automatic lsu_op_t model_op(input logic [2:0] en);
        if (en[2]) return OP_ATOMIC;
        if (en[1]) return OP_LOAD;
        return OP_STORE;
    endfunction

    task automatic issue_op(input logic [2:0] en, input logic [7:0] a, input logic [7:0] d,
                            input int rdl, input int wdl);
        rd_delay = rdl;
        wr_delay = wdl;
        @(negedge clk);
        core_state = CORE_REQUEST;
        {decoded_mem_atomic_enable, decoded_mem_read_enable, decoded_mem_write_enable} = en;
        rs = a;
        rt = d;
        @(posedge clk); #1;
        core_state = CORE_WAIT;
        {decoded_mem_atomic_enable, decoded_mem_read_enable, decoded_mem_write_enable} = 3'b000;
        rs = ~a;
        rt = ~d;
    endtask

    task automatic wait_done(output int lat, output logic done);
        int commits_before;
        commits_before = wr_commits;
        lat  = 1;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (lsu_state == LSU_DONE) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (wr_commits != commits_before) mem_array[last_wr_addr] = last_wr_data;
    endtask

    task automatic run_op(input logic [2:0] en, input logic [7:0] a, input logic [7:0] d,
                          input int rdl, input int wdl, output int lat, output logic done);
        issue_op(en, a, d, rdl, wdl);
        wait_done(lat, done);
        $display("op=%s rs=%02h rt=%02h rd_delay=%0d wr_delay=%0d -> out=%02h err=%0b cycles=%0d done=%0b",
                 model_op(en).name(), a, d, rdl, wdl, lsu_out, lsu_error, lat, done);
    endtask

    task automatic finish_op();
        core_state = CORE_UPDATE;
        @(posedge clk); #1;
        core_state = CORE_IDLE;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (lsu_state !== LSU_IDLE || bus.read_valid !== 1'b0 || bus.write_valid !== 1'b0 ||
            bus.read_address !== 8'h00 || bus.write_address !== 8'h00 || bus.write_data !== 8'h00 ||
            lsu_out !== 8'h00 || lsu_error !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got state=%s rv=%b wv=%b ra=%02h wa=%02h wd=%02h out=%02h err=%b, want IDLE and all zero",
                     lsu_state.name(), bus.read_valid, bus.write_valid, bus.read_address,
                     bus.write_address, bus.write_data, lsu_out, lsu_error);
        end
        @(negedge clk);
        reset = 1'b0;
        model_out = 8'h00;
    endtask

    task automatic test_load();
        int lat; logic done;
        mem_array[8'h12] = 8'h5A; ref_mem[8'h12] = 8'h5A;
        run_op(3'b010, 8'h12, 8'h00, 2, 0, lat, done);
        model_out = 8'h5A;
        n_cmp++;
        if (!done || lat != 5) begin
            n_bad++; $display("FAIL load_latency: got done=%b cycles=%0d, want done cycles=5", done, lat);
        end
        n_cmp++;
        if (last_rd_addr !== 8'h12 || lsu_out !== 8'h5A || lsu_error !== 1'b0) begin
            n_bad++; $display("FAIL load_result: got addr=%02h out=%02h err=%b, want 12 5a 0",
                              last_rd_addr, lsu_out, lsu_error);
        end
        finish_op();
        n_cmp++;
        if (lsu_state !== LSU_IDLE) begin
            n_bad++; $display("FAIL load_update_idle: got %s, want LSU_IDLE", lsu_state.name());
        end
    endtask

    task automatic test_store();
        int lat; logic done;
        run_op(3'b001, 8'h30, 8'hC3, NEVER, 0, lat, done);
        ref_mem[8'h30] = 8'hC3;
        n_cmp++;
        if (!done || lat != 3 || bus.write_valid !== 1'b0) begin
            n_bad++; $display("FAIL store_timing: got done=%b cycles=%0d wv=%b, want done cycles=3 wv=0",
                              done, lat, bus.write_valid);
        end
        n_cmp++;
        if (last_wr_addr !== 8'h30 || last_wr_data !== 8'hC3 || mem_array[8'h30] !== ref_mem[8'h30]) begin
            n_bad++; $display("FAIL store_capture: got addr=%02h data=%02h, want 30 c3", last_wr_addr, last_wr_data);
        end
        finish_op();
    endtask

    task automatic test_atomic();
        int lat; logic done;
        mem_array[8'h40] = 8'hF0; ref_mem[8'h40] = 8'hF0;
        overlap_seen = 1'b0;
        run_op(3'b100, 8'h40, 8'h20, 0, 0, lat, done);
        ref_mem[8'h40] = 8'h10;
        model_out = 8'hF0;
        n_cmp++;
        if (!done || lat != 5) begin
            n_bad++; $display("FAIL atomic_latency: got done=%b cycles=%0d, want done cycles=5", done, lat);
        end
        n_cmp++;
        if (last_rd_addr !== 8'h40 || last_wr_addr !== 8'h40 || mem_array[8'h40] !== 8'h10 ||
            lsu_out !== 8'hF0 || lsu_error !== 1'b0) begin
            n_bad++; $display("FAIL atomic_result: got ra=%02h wa=%02h mem=%02h out=%02h err=%b, want 40 40 10 f0 0",
                              last_rd_addr, last_wr_addr, mem_array[8'h40], lsu_out, lsu_error);
        end
        n_cmp++;
        if (overlap_seen !== 1'b0) begin
            n_bad++; $display("FAIL atomic_valid_overlap: got overlap=%b, want 0", overlap_seen);
        end
        finish_op();
    endtask

    task automatic test_timeout();
        int lat; logic done;
        run_op(3'b010, 8'h21, 8'h00, NEVER, 0, lat, done);
        n_cmp++;
        if (!done || lat != 2 + TMO || bus.read_valid !== 1'b0 || lsu_error !== 1'b1 || lsu_out !== model_out) begin
            n_bad++; $display("FAIL timeout_read: got done=%b cycles=%0d rv=%b err=%b out=%02h, want cycles=%0d rv=0 err=1 out=%02h",
                              done, lat, bus.read_valid, lsu_error, lsu_out, 2 + TMO, model_out);
        end
        finish_op();
        issue_op(3'b001, 8'h22, 8'h77, NEVER, 0);
        n_cmp++;
        if (lsu_error !== 1'b0) begin
            n_bad++; $display("FAIL timeout_error_clear: got err=%b after accept, want 0", lsu_error);
        end
        wait_done(lat, done);
        ref_mem[8'h22] = 8'h77;
        finish_op();
        // Atomic whose read times out: write phase skipped, memory and result unchanged.
        run_op(3'b100, 8'h22, 8'h01, NEVER, 0, lat, done);
        n_cmp++;
        if (!done || lat != 2 + TMO || lsu_error !== 1'b1 || lsu_out !== model_out || mem_array[8'h22] !== 8'h77) begin
            n_bad++; $display("FAIL timeout_atomic_read: got cycles=%0d err=%b out=%02h mem=%02h, want cycles=%0d err=1 out=%02h mem=77",
                              lat, lsu_error, lsu_out, mem_array[8'h22], 2 + TMO, model_out);
        end
        finish_op();
    endtask

    task automatic test_coincide();
        int lat; logic done;
        mem_array[8'h33] = 8'h9C; ref_mem[8'h33] = 8'h9C;
        run_op(3'b010, 8'h33, 8'h00, TMO - 1, 0, lat, done);
        model_out = 8'h9C;
        n_cmp++;
        if (!done || lat != 2 + TMO || lsu_error !== 1'b0 || lsu_out !== 8'h9C) begin
            n_bad++; $display("FAIL coincide_ready_wins: got cycles=%0d err=%b out=%02h, want cycles=%0d err=0 out=9c",
                              lat, lsu_error, lsu_out, 2 + TMO);
        end
        finish_op();
    endtask

    task automatic test_async_reset();
        logic reached;
        issue_op(3'b001, 8'h50, 8'hAA, NEVER, NEVER);
        reached = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (lsu_state == LSU_WAIT_WR) begin reached = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!reached || bus.write_valid !== 1'b1) begin
            n_bad++; $display("FAIL async_reach_wait_wr: got reached=%b wv=%b, want 1 1", reached, bus.write_valid);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.write_valid !== 1'b0 || lsu_state !== LSU_IDLE || lsu_out !== 8'h00) begin
            n_bad++; $display("FAIL async_reset_midclock: got wv=%b state=%s out=%02h, want 0 IDLE 00",
                              bus.write_valid, lsu_state.name(), lsu_out);
        end
        model_out = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        core_state = CORE_IDLE;
    endtask

    task automatic test_enable_hold();
        int lat; logic done; logic reached;
        lsu_atomic_state_t s0; logic rv0; logic [7:0] ra0, out0; logic err0;
        mem_array[8'h55] = 8'h3E; ref_mem[8'h55] = 8'h3E;
        issue_op(3'b010, 8'h55, 8'h00, 5, 0);
        reached = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (lsu_state == LSU_WAIT_RD) begin reached = 1'b1; break; end
            @(posedge clk); #1;
        end
        enable = 1'b0;
        s0 = lsu_state; rv0 = bus.read_valid; ra0 = bus.read_address; out0 = lsu_out; err0 = lsu_error;
        n_cmp++;
        if (!reached || rv0 !== 1'b1 || ra0 !== 8'h55) begin
            n_bad++; $display("FAIL enable_reach_wait_rd: got reached=%b rv=%b ra=%02h, want 1 1 55", reached, rv0, ra0);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (lsu_state !== s0 || bus.read_valid !== rv0 || bus.read_address !== ra0 ||
                lsu_out !== out0 || lsu_error !== err0) begin
                n_bad++; $display("FAIL enable_hold_cycle%0d: got state=%s rv=%b ra=%02h out=%02h err=%b, want %s %b %02h %02h %b",
                                  c, lsu_state.name(), bus.read_valid, bus.read_address, lsu_out, lsu_error,
                                  s0.name(), rv0, ra0, out0, err0);
            end
        end
        enable = 1'b1;
        // The ready pulse came and went while frozen, so the wait must time out.
        wait_done(lat, done);
        n_cmp++;
        if (!done || lsu_error !== 1'b1 || lsu_out !== model_out) begin
            n_bad++; $display("FAIL enable_missed_ready: got done=%b err=%b out=%02h, want 1 1 %02h",
                              done, lsu_error, lsu_out, model_out);
        end
        finish_op();
    endtask

    task automatic test_random();
        int lat, exp_lat, rdl, wdl; logic done, exp_err;
        logic [2:0] en; logic [7:0] a, d, exp_out;
        lsu_op_t op;
        for (int n = 0; n < 40; n++) begin
            en  = 3'($urandom_range(1, 7));
            a   = 8'($urandom);
            d   = 8'($urandom);
            rdl = $urandom_range(0, 5);
            wdl = $urandom_range(0, 5);
            op  = model_op(en);
            exp_out = model_out;
            exp_err = 1'b0;
            case (op)
                OP_LOAD: begin
                    if (rdl < TMO) begin exp_out = ref_mem[a]; exp_lat = 3 + rdl; end
                    else begin exp_err = 1'b1; exp_lat = 2 + TMO; end
                end
                OP_STORE: begin
                    if (wdl < TMO) begin ref_mem[a] = d; exp_lat = 3 + wdl; end
                    else begin exp_err = 1'b1; exp_lat = 2 + TMO; end
                end
                default: begin
                    if (rdl >= TMO) begin
                        exp_err = 1'b1; exp_lat = 2 + TMO;
                    end else begin
                        exp_out = ref_mem[a];
                        if (wdl < TMO) begin ref_mem[a] = ref_mem[a] + d; exp_lat = 5 + rdl + wdl; end
                        else begin exp_err = 1'b1; exp_lat = 4 + rdl + TMO; end
                    end
                end
            endcase
            run_op(en, a, d, rdl, wdl, lat, done);
            model_out = exp_out;
            n_cmp++;
            if (!done || lat != exp_lat || lsu_out !== exp_out || lsu_error !== exp_err ||
                mem_array[a] !== ref_mem[a]) begin
                n_bad++; $display("FAIL random_%0d: got done=%b cycles=%0d out=%02h err=%b mem=%02h, want cycles=%0d out=%02h err=%b mem=%02h",
                                  n, done, lat, lsu_out, lsu_error, mem_array[a], exp_lat, exp_out, exp_err, ref_mem[a]);
            end
            finish_op();
        end
    endtask

    initial begin
        enable = 1'b1;
        core_state = CORE_IDLE;
        {decoded_mem_atomic_enable, decoded_mem_read_enable, decoded_mem_write_enable} = 3'b000;
        rs = 8'h00;
        rt = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem_array[i] = 8'($urandom);
            ref_mem[i]   = mem_array[i];
        end
        test_reset();
        test_load();
        test_store();
        test_atomic();
        test_timeout();
        test_coincide();
        test_async_reset();
        test_enable_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/lsu_atomic.md
# lsu_atomic

Parametrised successor to the per-thread load-store unit. It executes LDR, STR and a new atomic fetch-and-add (ATM) instruction against the data-memory controller. It captures its operands at request time, bounds every memory wait with a timeout, and reports failures to the core. One instance sits beside each thread's ALU inside a core and is sequenced by the core's `corestate_t` scheduler.

## Interface
- `DATA_BITS`, default 8: data width of registers and memory words.
- `ADDR_BITS`, default 8: memory address width.
- `TIMEOUT_CYCLES`, default 255: maximum WAITING cycles before abort. 0 disables the timeout. Counter width is `$clog2(TIMEOUT_CYCLES+1)`.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `enable` in 1: thread active. When low, all state and outputs hold.
- `core_state` in `corestate_t`: core pipeline stage.
- `decoded_mem_read_enable` in 1: LDR.
- `decoded_mem_write_enable` in 1: STR.
- `decoded_mem_atomic_enable` in 1: ATM (mem[rs] += rt; returns old value).
- `rs` in `ADDR_BITS`: address operand.
- `rt` in `DATA_BITS`: store data / atomic addend.
- `mem_read_valid` out 1, `mem_read_address` out `ADDR_BITS`, `mem_read_ready` in 1, `mem_read_data` in `DATA_BITS`.
- `mem_write_valid` out 1, `mem_write_address` out `ADDR_BITS`, `mem_write_data` out `DATA_BITS`, `mem_write_ready` in 1.
- `lsu_state` out `lsu_atomic_state_t`: current state.
- `lsu_out` out `DATA_BITS`: loaded / pre-atomic value.
- `lsu_error` out 1: last operation timed out.

## Operation
- States: IDLE, REQ_RD, WAIT_RD, REQ_WR, WAIT_WR, DONE.
- IDLE:
  - Acts when `core_state==CORE_REQUEST` and any decoded enable is set.
  - Latches op, `rs` and `rt` into internal registers. Later changes on `rs`/`rt` are ignored.
  - Clears `lsu_error`.
  - Priority: atomic > read > write. Atomic or read go to REQ_RD; write goes to REQ_WR.
- REQ_RD: drive `mem_read_valid<=1` and `mem_read_address<=addr`, then go to WAIT_RD.
- WAIT_RD, on `mem_read_ready`:
  - Drive `mem_read_valid<=0` and `lsu_out<=mem_read_data`.
  - Read goes to DONE.
  - Atomic stores `mem_read_data + rt`, truncated mod 2^DATA_BITS, as the write data, then goes to REQ_WR.
- REQ_WR: drive `mem_write_valid<=1`, address and data, then go to WAIT_WR.
- WAIT_WR: on `mem_write_ready`, drive `mem_write_valid<=0` and go to DONE.
- Timeout:
  - The counter clears on entry to either WAIT state and increments each enabled WAIT cycle without ready.
  - When it reaches `TIMEOUT_CYCLES`, drop the active valid, set `lsu_error<=1`, and go to DONE.
  - On an atomic read timeout, the write phase is skipped and `lsu_out` holds its previous value.
- DONE: when `core_state==CORE_UPDATE`, go to IDLE. `lsu_out` and `lsu_error` hold until the next accepted request.
- Ready input not matching the current WAIT state is ignored, as is ready in REQ states.

## Timing
- Reset values:
  - `lsu_state`=IDLE.
  - `mem_*_valid`=0.
  - Addresses, write data and `lsu_out` = 0.
  - `lsu_error`=0; timeout counter 0.
- Valid is registered: asserted one cycle after entering REQ_*. Earliest ready is sampled the cycle after that.
- Minimum latency from CORE_REQUEST acceptance to DONE:
  - Read/write: 3 cycles, with ready already high.
  - Atomic: 5 cycles.
- Valid stays high until the ready edge. Address and data are stable while valid is high.
- Ready and timeout in the same cycle: ready wins (success, no error).
- `enable` low mid-transaction freezes state, counter and valids. Memory may still complete; the ready is seen when `enable` returns only if still asserted.
- Reset mid-transaction drops valids immediately (asynchronously).

## Structure
- In the shared `enums.svh` package:
  - `lsu_atomic_state_t` (6 states).
  - `lsu_op_t` (OP_NONE/LOAD/STORE/ATOMIC).
- `corestate_t` is reused unchanged.
- Sub-module `lsu_timeout_counter`, holding `TIMEOUT_CYCLES`, with clear / count-enable / expired ports.

## Test plan
1. Load: rs=0x12, memory returns 0x5A with ready 2 cycles after valid → `mem_read_address`=0x12, `lsu_out`=0x5A, DONE, `lsu_error`=0. IDLE after CORE_UPDATE.
2. Store: rs=0x30, rt=0xC3; change rs/rt to 0xFF the cycle after acceptance → write address 0x30, data 0xC3. `mem_write_valid` falls on the ready cycle.
3. Atomic: mem[0x40]=0xF0, rt=0x20 → read 0x40, then write 0x10 (wrap) to 0x40; `lsu_out`=0xF0; read valid never overlaps write valid.
4. Timeout: TIMEOUT_CYCLES=4, ready never asserted → valid drops after 4 WAIT cycles, `lsu_error`=1, DONE. The next accepted request clears `lsu_error`.
5. Ready and timeout coincide on the last count → success, `lsu_out` updated, `lsu_error`=0.
6. Async reset asserted in WAIT_WR, mid-clock → `mem_write_valid`=0 before the next edge, state IDLE. `enable`=0 during WAIT_RD holds all outputs for 10 cycles.
